// File: rtl/clk_phase_gen.sv
// Phase generator for the CPU clock family with cycle-boundary gating,
// oscillator-stabilisation counting and a delayed synchronous CPU reset.
module clk_phase_gen #(
  parameter int unsigned PHASES        = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned SYNC_DELAY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_ena,
  input  logic              clk_ena,
  output logic [PHASES-1:0] phase,
  output logic              main_clk_p,
  output logic              main_clk_n,
  output logic              data_clk_p,
  output logic              data_clk_n,
  output logic              inc_clk_p,
  output logic              inc_clk_n,
  output logic              adr_clk_p,
  output logic              adr_clk_n,
  output logic              latch_clk,
  output logic              running,
  output logic              osc_stable,
  output logic              sync_reset,
  output logic              async_reset
);

  localparam int unsigned CW = (PHASES > 1) ? $clog2(PHASES) : 1;
  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned DW = $clog2(SYNC_DELAY + 1);

  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic [SW-1:0]     stable_cnt;
  logic [DW-1:0]     dly_cnt;
  logic              wrap;
  logic              running_nxt;
  logic [PHASES-1:0] phase_nxt;
  logic              d_main;
  logic              d_data;
  logic              d_inc;
  logic              d_adr;
  logic              d_latch;

  assign async_reset = rst;

  // Decode from the next counter value so outputs line up with the counter.
  always_comb begin
    wrap        = 1'b0;
    cnt_nxt     = cnt;
    running_nxt = running;
    if (osc_ena) begin
      wrap    = (cnt == CW'(PHASES - 1));
      cnt_nxt = wrap ? '0 : cnt + 1'b1;
      if (wrap)
        running_nxt = clk_ena & osc_stable;
    end
    phase_nxt = PHASES'(1) << cnt_nxt;
    d_main    = (cnt_nxt < CW'(PHASES / 2));
    d_data    = running_nxt & ~d_main;
    d_inc     = running_nxt & (cnt_nxt == CW'(PHASES - 1));
    d_adr     = running_nxt & (cnt_nxt != '0) & (cnt_nxt != CW'(PHASES - 1));
    d_latch   = running_nxt & (cnt_nxt == CW'(PHASES / 2 - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      phase      <= PHASES'(1);
      main_clk_p <= 1'b1;
      main_clk_n <= 1'b0;
      data_clk_p <= 1'b0;
      data_clk_n <= 1'b1;
      inc_clk_p  <= 1'b0;
      inc_clk_n  <= 1'b1;
      adr_clk_p  <= 1'b0;
      adr_clk_n  <= 1'b1;
      latch_clk  <= 1'b0;
      running    <= 1'b0;
      osc_stable <= 1'b0;
      stable_cnt <= '0;
      dly_cnt    <= '0;
      sync_reset <= 1'b1;
    end else if (!osc_ena) begin
      // Stop mode: clocks freeze, stabilisation must start over.
      stable_cnt <= '0;
      osc_stable <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      phase      <= phase_nxt;
      main_clk_p <= d_main;
      main_clk_n <= ~d_main;
      data_clk_p <= d_data;
      data_clk_n <= ~d_data;
      inc_clk_p  <= d_inc;
      inc_clk_n  <= ~d_inc;
      adr_clk_p  <= d_adr;
      adr_clk_n  <= ~d_adr;
      latch_clk  <= d_latch;
      running    <= running_nxt;
      if (wrap && !osc_stable && (stable_cnt != SW'(STABLE_CYCLES))) begin
        stable_cnt <= stable_cnt + 1'b1;
        if (stable_cnt == SW'(STABLE_CYCLES - 1))
          osc_stable <= 1'b1;
      end
      if (wrap && osc_stable && sync_reset) begin
        dly_cnt <= dly_cnt + 1'b1;
        if (dly_cnt == DW'(SYNC_DELAY - 1))
          sync_reset <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: default 8-phase instance plus a
// minimal 4-phase instance sharing clock, reset and enables.
module tb_clk_phase_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       osc_ena;
  logic       clk_ena;

  logic [7:0] phase;
  logic main_p, main_n, data_p, data_n, inc_p, inc_n, adr_p, adr_n;
  logic latch, running, osc_stable, sync_reset, async_reset;

  logic [3:0] s_phase;
  logic s_main_p, s_main_n, s_data_p, s_data_n, s_inc_p, s_inc_n, s_adr_p, s_adr_n;
  logic s_latch, s_running, s_osc_stable, s_sync_reset, s_async_reset;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;
  int ph       = 0;

  always #5 clk = ~clk;

  clk_phase_gen u_dut (
    .clk(clk), .rst(rst), .osc_ena(osc_ena), .clk_ena(clk_ena),
    .phase(phase),
    .main_clk_p(main_p), .main_clk_n(main_n),
    .data_clk_p(data_p), .data_clk_n(data_n),
    .inc_clk_p(inc_p), .inc_clk_n(inc_n),
    .adr_clk_p(adr_p), .adr_clk_n(adr_n),
    .latch_clk(latch), .running(running), .osc_stable(osc_stable),
    .sync_reset(sync_reset), .async_reset(async_reset)
  );

  clk_phase_gen #(.PHASES(4), .STABLE_CYCLES(1), .SYNC_DELAY(1)) u_small (
    .clk(clk), .rst(rst), .osc_ena(osc_ena), .clk_ena(clk_ena),
    .phase(s_phase),
    .main_clk_p(s_main_p), .main_clk_n(s_main_n),
    .data_clk_p(s_data_p), .data_clk_n(s_data_n),
    .inc_clk_p(s_inc_p), .inc_clk_n(s_inc_n),
    .adr_clk_p(s_adr_p), .adr_clk_n(s_adr_n),
    .latch_clk(s_latch), .running(s_running), .osc_stable(s_osc_stable),
    .sync_reset(s_sync_reset), .async_reset(s_async_reset)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (osc_ena && !rst) ph = (ph + 1) % 8;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  task automatic goto_phase(input int p);
    do tick(); while (ph != p);
  endtask

  // Expected 8-phase waveform for the bench's own phase count.
  task automatic check_wave(input string tag, input bit run);
    bit m, d, i, a, l;
    m = (ph < 4);
    d = run && (ph >= 4);
    i = run && (ph == 7);
    a = run && (ph >= 1) && (ph <= 6);
    l = run && (ph == 3);
    check({tag, ".phase"}, 32'(phase), 32'(1) << ph);
    check({tag, ".main_p"}, 32'(main_p), 32'(m));
    check({tag, ".main_n"}, 32'(main_n), 32'(!m));
    check({tag, ".data_p"}, 32'(data_p), 32'(d));
    check({tag, ".data_n"}, 32'(data_n), 32'(!d));
    check({tag, ".inc_p"}, 32'(inc_p), 32'(i));
    check({tag, ".inc_n"}, 32'(inc_n), 32'(!i));
    check({tag, ".adr_p"}, 32'(adr_p), 32'(a));
    check({tag, ".adr_n"}, 32'(adr_n), 32'(!a));
    check({tag, ".latch"}, 32'(latch), 32'(l));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".phase"}, 32'(phase), 32'h01);
    check({tag, ".main_p"}, 32'(main_p), 32'd1);
    check({tag, ".main_n"}, 32'(main_n), 32'd0);
    check({tag, ".data_p"}, 32'(data_p), 32'd0);
    check({tag, ".data_n"}, 32'(data_n), 32'd1);
    check({tag, ".inc_p"}, 32'(inc_p), 32'd0);
    check({tag, ".inc_n"}, 32'(inc_n), 32'd1);
    check({tag, ".adr_p"}, 32'(adr_p), 32'd0);
    check({tag, ".adr_n"}, 32'(adr_n), 32'd1);
    check({tag, ".latch"}, 32'(latch), 32'd0);
    check({tag, ".running"}, 32'(running), 32'd0);
    check({tag, ".osc_stable"}, 32'(osc_stable), 32'd0);
    check({tag, ".sync_reset"}, 32'(sync_reset), 32'd1);
    check({tag, ".async_reset"}, 32'(async_reset), 32'd1);
    check({tag, ".s_phase"}, 32'(s_phase), 32'h1);
    check({tag, ".s_sync_reset"}, 32'(s_sync_reset), 32'd1);
  endtask

  // Expects edge_n == 0 and phase 0 immediately after reset release.
  task automatic startup_check(input string tag);
    int p4;
    run_to(3);
    check({tag, ".s_stable@3"}, 32'(s_osc_stable), 32'd0);
    run_to(4);
    check({tag, ".s_stable@4"}, 32'(s_osc_stable), 32'd1);
    check({tag, ".s_running@4"}, 32'(s_running), 32'd0);
    run_to(7);
    check({tag, ".s_running@7"}, 32'(s_running), 32'd0);
    check({tag, ".s_sync@7"}, 32'(s_sync_reset), 32'd1);
    run_to(8);
    check({tag, ".s_running@8"}, 32'(s_running), 32'd1);
    check({tag, ".s_sync@8"}, 32'(s_sync_reset), 32'd0);
    for (int e = 9; e <= 12; e++) begin
      run_to(e);
      p4 = edge_n % 4;
      check({tag, ".s_phase"}, 32'(s_phase), 32'(1) << p4);
      check({tag, ".s_main"}, 32'(s_main_p), 32'(p4 < 2));
      check({tag, ".s_data"}, 32'(s_data_p), 32'(p4 >= 2));
      check({tag, ".s_inc"}, 32'(s_inc_p), 32'(p4 == 3));
      check({tag, ".s_adr"}, 32'(s_adr_p), 32'(p4 == 1 || p4 == 2));
      check({tag, ".s_latch"}, 32'(s_latch), 32'(p4 == 1));
    end
    run_to(127);
    check({tag, ".stable@127"}, 32'(osc_stable), 32'd0);
    run_to(128);
    check({tag, ".stable@128"}, 32'(osc_stable), 32'd1);
    check({tag, ".running@128"}, 32'(running), 32'd0);
    check_wave({tag, ".w128"}, 1'b0);
    run_to(135);
    check({tag, ".running@135"}, 32'(running), 32'd0);
    check_wave({tag, ".w135"}, 1'b0);
    run_to(136);
    check({tag, ".running@136"}, 32'(running), 32'd1);
    check({tag, ".sync@136"}, 32'(sync_reset), 32'd1);
    run_to(143);
    check({tag, ".sync@143"}, 32'(sync_reset), 32'd1);
    run_to(144);
    check({tag, ".sync@144"}, 32'(sync_reset), 32'd0);
  endtask

  initial begin
    rst     = 1'b1;
    osc_ena = 1'b1;
    clk_ena = 1'b1;

    // Reset held for three clocks.
    repeat (3) tick();
    check_reset_vals("reset");
    rst    = 1'b0;
    edge_n = 0;
    ph     = 0;
    #1;
    check("async_reset.low", 32'(async_reset), 32'd0);

    startup_check("start");
    for (int k = 0; k < 8; k++) begin
      tick();
      check_wave("run", 1'b1);
    end

    // Halt: drop CLK_ENA in phase 5, current pulses complete.
    goto_phase(5);
    clk_ena = 1'b0;
    tick(); check_wave("halt.ph6", 1'b1);
    tick(); check_wave("halt.ph7", 1'b1);
    tick();
    check("halt.running", 32'(running), 32'd0);
    check_wave("halt.ph0", 1'b0);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_wave("halted", 1'b0);
    end
    goto_phase(2);
    clk_ena = 1'b1;
    for (int k = 3; k < 8; k++) begin
      tick();
      check_wave("resume.wait", 1'b0);
    end
    tick();
    check("resume.running", 32'(running), 32'd1);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_wave("resumed", 1'b1);
    end

    // Stop mode entered in phase 3.
    goto_phase(3);
    osc_ena = 1'b0;
    repeat (20) tick();
    check("stop.phase", 32'(phase), 32'h08);
    check("stop.latch", 32'(latch), 32'd1);
    check("stop.adr", 32'(adr_p), 32'd1);
    check("stop.main", 32'(main_p), 32'd1);
    check("stop.running", 32'(running), 32'd1);
    check("stop.stable", 32'(osc_stable), 32'd0);
    check("stop.sync", 32'(sync_reset), 32'd0);
    osc_ena = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tick();
      check_wave("stop.tail", 1'b1);
    end
    for (int w = 1; w <= 17; w++) begin
      goto_phase(0);
      if (w == 1) begin
        check("restab.running.w1", 32'(running), 32'd0);
        check_wave("restab.w1", 1'b0);
      end
      if (w == 15) check("restab.stable.w15", 32'(osc_stable), 32'd0);
      if (w == 16) begin
        check("restab.stable.w16", 32'(osc_stable), 32'd1);
        check("restab.running.w16", 32'(running), 32'd0);
      end
      if (w == 17) check("restab.running.w17", 32'(running), 32'd1);
      check("restab.sync", 32'(sync_reset), 32'd0);
    end

    // Asynchronous reset in phase 6 while running.
    goto_phase(6);
    check("pre_rst.data", 32'(data_p), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    repeat (2) tick();
    rst    = 1'b0;
    edge_n = 0;
    ph     = 0;
    startup_check("restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_phase_gen.md
# clk_phase_gen

Parametrised successor to the fixed four-latch external clock divider. It divides the fast oscillator clock into a configurable number of phases per machine cycle and produces the CPU clock family: MAIN, DATA, INC, ADR and LATCH. CPU clock gating is applied only at machine-cycle boundaries, so no pulse is ever truncated. An oscillator-stabilisation counter and a delayed synchronous CPU reset sit beside the phase generator, between the pad clock and the CPU core.

## Interface
- PHASES, 8: clock phases per machine cycle; must be even and ≥4.
- STABLE_CYCLES, 16: machine cycles of running oscillator required before OSC_STABLE; must be ≥1.
- SYNC_DELAY, 2: machine cycles between OSC_STABLE and SYNC_RESET release; must be ≥1.
- CLK  in  1  fast oscillator clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset (single clock domain, CLK).
- OSC_ENA  in  1  oscillator enable; 0 = stop mode.
- CLK_ENA  in  1  CPU clock enable; 0 = halt.
- PHASE  out  PHASES  one-hot current phase.
- MAIN_CLK_P / MAIN_CLK_N  out  1  free-running machine clock and its complement.
- DATA_CLK_P / DATA_CLK_N  out  1  gated data clock and its complement.
- INC_CLK_P / INC_CLK_N  out  1  gated increment clock (last phase) and its complement.
- ADR_CLK_P / ADR_CLK_N  out  1  gated address-valid clock and its complement.
- LATCH_CLK  out  1  gated single-phase latch strobe.
- RUNNING  out  1  CPU clock gate state.
- OSC_STABLE  out  1  oscillator stabilised.
- SYNC_RESET  out  1  synchronous CPU reset, active-high.
- ASYNC_RESET  out  1  combinational copy of RESET.

## Operation

**Phase counter**
- Counts 0..PHASES-1 and wraps to 0. Width is clog2(PHASES).
- Advances only when OSC_ENA=1. When OSC_ENA=0 the counter and all decoded clocks hold (stop mode).
- A "wrap edge" is the clock edge taking the counter from PHASES-1 to 0.

**Decoded clocks**
- All outputs are registered and change on the same edge as the counter. All N outputs are exact complements of their P outputs.
- MAIN_CLK_P = 1 in phases 0..PHASES/2-1. It is never gated by CLK_ENA.
- Ungated decodes:
  - DATA: phases PHASES/2..PHASES-1.
  - INC: phase PHASES-1.
  - ADR: phases 1..PHASES-2.
  - LATCH: phase PHASES/2-1.
- Gating: each gated P output = ungated decode AND RUNNING.

**Gate control**
- RUNNING updates only on a wrap edge: RUNNING ← CLK_ENA AND OSC_STABLE, using values sampled before that edge.
- All gated decodes are 0 in phase 0, so a change in RUNNING never truncates a pulse.
- A CLK_ENA change mid-cycle takes effect at the next wrap edge.

**Stabilisation**
- The stable counter (width clog2(STABLE_CYCLES+1)) increments on each wrap edge while OSC_STABLE=0. It saturates.
- OSC_STABLE rises on the wrap edge at which the count reaches STABLE_CYCLES.
- OSC_ENA=0 clears the stable counter and OSC_STABLE on the next CLK edge. On resume, stabilisation restarts. RUNNING stays 0 until OSC_STABLE is re-established and a further wrap edge occurs.

**Sync reset**
- The delay counter increments on wrap edges where the pre-edge OSC_STABLE=1.
- SYNC_RESET falls on the wrap edge at which the delay count reaches SYNC_DELAY.
- Once 0, SYNC_RESET stays 0 until RESET. Stop mode does not re-assert it.

**Reset values** (RESET=1, asynchronous)
- Counter 0, PHASE=1, MAIN_CLK_P=1.
- All gated P outputs 0; all N outputs = ~P.
- RUNNING=0, OSC_STABLE=0, SYNC_RESET=1.
- Stable and delay counters cleared.
- Reset asserted mid-cycle forces these values immediately, without waiting for a clock edge.

## Timing
Example parameters: PHASES=8, STABLE_CYCLES=16, SYNC_DELAY=2. OSC_ENA=CLK_ENA=1; edge 1 is the first edge after RESET falls.
- Counter reaches phase n at edge n; wrap edges occur at 8, 16, 24, …
- OSC_STABLE rises at edge 128.
- RUNNING rises at edge 136.
- SYNC_RESET falls at edge 144.
- Per machine cycle, once running:
  - MAIN high for 4 phases.
  - DATA high for phases 4–7.
  - INC high for phase 7 only.
  - ADR high for phases 1–6.
  - LATCH high for phase 3 only.
- Output latency from counter state is 0: outputs are registered from the next-state decode.

## Test plan
- **Reset:** hold RESET for 3 CLK → PHASE=8'h01, MAIN_CLK_P=1, all gated P=0, all N=~P, SYNC_RESET=1, OSC_STABLE=0, RUNNING=0; ASYNC_RESET follows RESET combinationally.
- **Startup:** defaults, OSC_ENA=CLK_ENA=1 → OSC_STABLE at edge 128, RUNNING at 136, SYNC_RESET low at 144; then the per-phase waveform above repeats every 8 edges.
- **Halt:** CLK_ENA low in phase 5 → the current DATA/INC pulses complete; RUNNING falls at the next wrap edge; gated outputs stay 0; MAIN keeps toggling. CLK_ENA high in phase 2 → clocks resume at the following wrap edge, starting with a full cycle.
- **Stop mode:** OSC_ENA low for 20 CLK in phase 3 → all outputs frozen; OSC_STABLE falls and RUNNING falls at the next wrap. On resume, 16 machine cycles elapse before OSC_STABLE and one more before RUNNING; SYNC_RESET stays 0 throughout.
- **Reset mid-operation:** RESET pulse in phase 6 while running → outputs return to reset values asynchronously; the full 128/136/144 sequence repeats after release.
- **Parameters:** PHASES=4, STABLE_CYCLES=1, SYNC_DELAY=1 → OSC_STABLE at edge 4, RUNNING and SYNC_RESET low at edge 8; INC in phase 3, LATCH in phase 1, ADR in phases 1–2.
